max7219_bcd_convert: RTL and testbench

MAX7219_BCD_CONVERT -- requirements
Module: max7219_bcd_convert

---
 rtl/max7219_bcd_convert.sv | 130 +++++++++++++
 tb/tb_max7219_bcd_convert.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/max7219_bcd_convert.sv
// Serial double-dabble binary-to-BCD converter feeding the MAX7219 DATA bus.
// Optional overflow saturation is enabled with `define MAX7219_BCD_SATURATE_EN.
module max7219_bcd_convert #(
  parameter int unsigned BIN_WIDTH = 27
) (
  input  logic                 CLK_IN,
  input  logic                 RST,
  input  logic [BIN_WIDTH-1:0] BIN,
  input  logic                 START,
  output logic [31:0]          DATA,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 OVF
);

  localparam int unsigned CW = $clog2(BIN_WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                  state_q, state_d;
  logic [BIN_WIDTH-1:0]    bin_q, bin_d;
  logic [31:0]             scr_q, scr_d;
  logic [31:0]             data_q, data_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic [31:0]             scr_adj;
  logic [31+BIN_WIDTH:0]   shifted;

`ifdef MAX7219_BCD_SATURATE_EN
  localparam logic [31:0] BCD_MAX = 32'd99_999_999;
  logic sat_q, sat_d;
  logic ovf_q, ovf_d;
  logic over_max;

  // Inputs of 26 bits or fewer can never exceed 99,999,999.
  if (BIN_WIDTH <= 26) begin : g_no_cmp
    assign over_max = 1'b0;
  end else begin : g_cmp
    assign over_max = 32'(BIN) > BCD_MAX;
  end
`endif

  always_comb begin
    scr_adj = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      scr_adj[4*k +: 4] = (scr_q[4*k +: 4] >= 4'd5) ? scr_q[4*k +: 4] + 4'd3
                                                      : scr_q[4*k +: 4];
    end
    // Digit 7 carry-out falls off the top, leaving the value mod 10^8.
    shifted = {scr_adj, bin_q} << 1;
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    done_d  = 1'b0;
`ifdef MAX7219_BCD_SATURATE_EN
    sat_d   = sat_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (START) begin
          bin_d   = BIN;
          scr_d   = '0;
          cnt_d   = CW'(BIN_WIDTH);
          state_d = SHIFT;
`ifdef MAX7219_BCD_SATURATE_EN
          sat_d   = over_max;
`endif
        end
      end
      SHIFT: begin
        scr_d = shifted[31+BIN_WIDTH:BIN_WIDTH];
        bin_d = shifted[BIN_WIDTH-1:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
`ifdef MAX7219_BCD_SATURATE_EN
          data_d  = sat_q ? 32'h9999_9999 : shifted[31+BIN_WIDTH:BIN_WIDTH];
          ovf_d   = sat_q;
`else
          data_d  = shifted[31+BIN_WIDTH:BIN_WIDTH];
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_IN) begin
    if (!RST) begin
      state_q <= IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
`ifdef MAX7219_BCD_SATURATE_EN
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      done_q  <= done_d;
`ifdef MAX7219_BCD_SATURATE_EN
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign DATA = data_q;
  assign BUSY = (state_q == SHIFT);
  assign DONE = done_q;
`ifdef MAX7219_BCD_SATURATE_EN
  assign OVF  = ovf_q;
`else
  assign OVF  = 1'b0;
`endif

endmodule

// File: tb/tb_max7219_bcd_convert.sv
// Scoreboard bench for max7219_bcd_convert: results are queued at acceptance
// and compared on the cycle a completion is due.
module tb_max7219_bcd_convert;

  localparam int unsigned W = 27;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  bin;
  logic          start;
  logic [31:0]   data;
  logic          busy;
  logic          done;
  logic          ovf;

  int unsigned   n_checks;
  int unsigned   n_fail;
  int unsigned   dut_dones;
  int unsigned   model_dones;

  logic [32:0]   sb_q[$];
  int unsigned   m_left;
  logic          m_done;
  logic [31:0]   m_hold;
  logic          m_ovf;

  max7219_bcd_convert #(.BIN_WIDTH(W)) dut (
    .CLK_IN (clk),
    .RST    (rst_n),
    .BIN    (bin),
    .START  (start),
    .DATA   (data),
    .BUSY   (busy),
    .DONE   (done),
    .OVF    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Decimal digits computed arithmetically, independent of the add-3 algorithm.
  function automatic logic [32:0] expect_of(input logic [W-1:0] v);
    int unsigned r;
    logic [31:0] d;
    r = int'(v);
`ifdef MAX7219_BCD_SATURATE_EN
    if (r > 99_999_999) return {1'b1, 32'h9999_9999};
`endif
    r = r % 100_000_000;
    d = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      d[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return {1'b0, d};
  endfunction

  initial begin
    m_left = 0; m_done = 1'b0; m_hold = '0; m_ovf = 1'b0;
  end

  always @(negedge clk) begin
    logic [32:0] e;
    if (done) dut_dones++;
    if (m_done) begin
      model_dones++;
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        m_ovf  = e[32];
        m_hold = e[31:0];
      end
    end
    chk("busy", {31'd0, busy}, {31'd0, m_left != 0});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk(m_done ? "result" : "hold", data, m_hold);
    chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
    if (!rst_n) begin
      m_left = 0; m_done = 1'b0; m_hold = '0; m_ovf = 1'b0;
      sb_q.delete();
    end else begin
      m_done = (m_left == 1);
      if (m_left != 0) m_left--;
      else if (start) begin
        m_left = W;
        sb_q.push_back(expect_of(bin));
      end
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse(input logic [W-1:0] v);
    start = 1'b1; bin = v;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; bin = '0;
    n_checks = 0; n_fail = 0; dut_dones = 0; model_dones = 0;
    step(3);
    chk("reset_data", data, 32'h0);
    rst_n = 1'b1;
    step(1);

    pulse('0);                step(30);
    pulse(W'(12_345_678));    step(30);
    pulse(W'(134_217_727));   step(30);

    // START held: back-to-back conversions, BIN wiggles while busy
    start = 1'b1; bin = W'(99_999_999);
    step(5);  bin = W'(123);
    step(15); bin = W'(99_999_999);
    step(40);
    start = 1'b0;
    step(30);

    // Second START while busy must be ignored
    pulse(W'(5));
    step(8);
    pulse(W'(7));
    step(30);

    // Reset mid-conversion aborts without DONE
    pulse(W'(42));
    step(10);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(3);
    pulse(W'(42));            step(30);

    for (int i = 0; i < 3; i++) begin
      pulse(W'($urandom_range(0, 134_217_727)));
      step(30);
    end

    chk("sb_empty", sb_q.size(), 32'd0);
    chk("done_count", dut_dones, model_dones);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
